// File: rtl/gam_weight_update_seq_pkg.sv
// Shared types and default sizing for the GAM weight/threshold update engine.
package gam_weight_update_seq_pkg;

  localparam int VECTOR_LEN_DEF = 8;
  localparam int ELEM_W_DEF     = 8;
  localparam int M_W_DEF        = 16;
  localparam int TH_W_DEF       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } gam_upd_state_T;

endpackage

// File: rtl/gam_weight_update_seq_if.sv
// Request/response bundle between winner search, the update engine and node-memory write-back.
interface gam_weight_update_seq_if #(
  parameter int VECTOR_LEN = gam_weight_update_seq_pkg::VECTOR_LEN_DEF,
  parameter int ELEM_W     = gam_weight_update_seq_pkg::ELEM_W_DEF,
  parameter int M_W        = gam_weight_update_seq_pkg::M_W_DEF,
  parameter int TH_W       = gam_weight_update_seq_pkg::TH_W_DEF
);
  // Both sides use valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and data stable until then, and ready never depends on valid.
  logic                         in_valid;
  logic                         in_ready;
  logic [VECTOR_LEN*ELEM_W-1:0] x_in;
  logic [VECTOR_LEN*ELEM_W-1:0] ws1_in;
  logic [VECTOR_LEN*ELEM_W-1:0] ws2_in;
  logic [M_W-1:0]               ms1_in;
  logic [M_W-1:0]               ms2_in;
  logic [TH_W-1:0]              ths1_in;
  logic [TH_W-1:0]              min1_ed_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [VECTOR_LEN*ELEM_W-1:0] ws1_out;
  logic [VECTOR_LEN*ELEM_W-1:0] ws2_out;
  logic [TH_W-1:0]              ths1_out;

  modport master (
    output in_valid, x_in, ws1_in, ws2_in, ms1_in, ms2_in, ths1_in, min1_ed_in, out_ready,
    input  in_ready, out_valid, ws1_out, ws2_out, ths1_out
  );

  modport slave (
    input  in_valid, x_in, ws1_in, ws2_in, ms1_in, ms2_in, ths1_in, min1_ed_in, out_ready,
    output in_ready, out_valid, ws1_out, ws2_out, ths1_out
  );
endinterface

// File: rtl/gam_weight_update_seq_sdiv_iter.sv
// gam_sdiv_iter: restoring sign-magnitude divider, one quotient bit per cycle, truncating toward zero.
module gam_sdiv_iter #(
  parameter int DIVIDEND_W = 9,
  parameter int DIVISOR_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic        [DIVISOR_W-1:0]  divisor,
  output logic signed [DIVIDEND_W-1:0] quotient,
  output logic                         done
);
  localparam int MAG_W = DIVIDEND_W - 1;
  localparam int CNT_W = $clog2(MAG_W + 1);

  logic [DIVIDEND_W-1:0] neg_dividend;
  logic [MAG_W-1:0]      mag_in, dvd_q, dvd_src, qm_q, qm_src;
  logic [DIVISOR_W-1:0]  rem_q, rem_src, rem_n, dsr_q, dsr_src;
  logic [DIVISOR_W:0]    trial, trial_sub;
  logic [CNT_W-1:0]      cnt_q, cnt_src;
  logic                  busy_q, neg_q, step, ge;

  // The start cycle already performs the first step on the port values.
  always_comb begin
    neg_dividend = -dividend;
    mag_in    = dividend[DIVIDEND_W-1] ? neg_dividend[MAG_W-1:0] : dividend[MAG_W-1:0];
    step      = start || busy_q;
    rem_src   = start ? '0 : rem_q;
    dvd_src   = start ? mag_in : dvd_q;
    dsr_src   = start ? divisor : dsr_q;
    qm_src    = start ? '0 : qm_q;
    cnt_src   = start ? '0 : cnt_q;
    trial     = {rem_src, dvd_src[MAG_W-1]};
    trial_sub = trial - {1'b0, dsr_src};
    ge        = (trial >= {1'b0, dsr_src});
    rem_n     = ge ? trial_sub[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    done      = step && (cnt_src == CNT_W'(MAG_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      qm_q   <= '0;
    end else if (step) begin
      busy_q <= !done;
      neg_q  <= start ? dividend[DIVIDEND_W-1] : neg_q;
      cnt_q  <= cnt_src + CNT_W'(1);
      rem_q  <= rem_n;
      dvd_q  <= {dvd_src[MAG_W-2:0], 1'b0};
      dsr_q  <= dsr_src;
      qm_q   <= {qm_src[MAG_W-2:0], ge};
    end
  end

  always_comb begin
    quotient = '0;
    if (dsr_q != '0) quotient = neg_q ? -$signed({1'b0, qm_q}) : $signed({1'b0, qm_q});
  end
endmodule

// File: rtl/gam_weight_update_seq.sv
// GAM learning-path update: W <- W + (X-W)/M per element, Th <- (Th+minED)/2.
// Define GAM_WS2_UPDATE_EN to also update the second-winner vector through its own divider lane.
module gam_weight_update_seq
  import gam_weight_update_seq_pkg::*;
#(
  parameter int VECTOR_LEN = VECTOR_LEN_DEF,
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int M_W        = M_W_DEF,
  parameter int TH_W       = TH_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  gam_weight_update_seq_if.slave bus,
  output gam_upd_state_T dbg_state
);
  localparam int DW    = ELEM_W + 1;
  localparam int VW    = VECTOR_LEN * ELEM_W;
  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;

  gam_upd_state_T      state_q, state_d;
  logic                out_valid_q, out_valid_d, div_start_q, div_go;
  logic                accept, write_en, last_elem, publish;
  logic [IDX_W-1:0]    idx_q;
  logic [VW-1:0]       x_q, w1_q, w2_q, ws1_out_q, ws2_out_q;
  logic [M_W-1:0]      ms1_q;
  logic [TH_W-1:0]     ths_q, ths1_out_q;
  logic [TH_W:0]       th_sum;
  logic [ELEM_W-1:0]   x_e, w1_e, upd1;
  logic signed [DW-1:0] diff1, q1;
  logic signed [DW:0]  sum1;
  logic                div1_done;

  always_comb begin
    th_sum = {1'b0, bus.ths1_in} + {1'b0, bus.min1_ed_in};
    x_e    = x_q[idx_q*ELEM_W +: ELEM_W];
    w1_e   = w1_q[idx_q*ELEM_W +: ELEM_W];
    diff1  = $signed({1'b0, x_e}) - $signed({1'b0, w1_e});
    sum1   = $signed({2'b00, w1_e}) + $signed({q1[DW-1], q1});
    // Top two bits of the sum flag underflow (sign) and overflow past the element range.
    upd1   = sum1[DW] ? '0 : (sum1[DW-1] ? '1 : sum1[ELEM_W-1:0]);
  end

  gam_sdiv_iter #(.DIVIDEND_W(DW), .DIVISOR_W(M_W)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(div_start_q),
    .dividend(diff1), .divisor(ms1_q), .quotient(q1), .done(div1_done)
  );

`ifdef GAM_WS2_UPDATE_EN
  logic [M_W-1:0]       ms2_q;
  logic [ELEM_W-1:0]    w2_e, upd2;
  logic signed [DW-1:0] diff2, q2;
  logic signed [DW:0]   sum2;
  logic                 div2_done;

  always_comb begin
    w2_e  = w2_q[idx_q*ELEM_W +: ELEM_W];
    diff2 = $signed({1'b0, x_e}) - $signed({1'b0, w2_e});
    sum2  = $signed({2'b00, w2_e}) + $signed({q2[DW-1], q2});
    upd2  = sum2[DW] ? '0 : (sum2[DW-1] ? '1 : sum2[ELEM_W-1:0]);
  end

  gam_sdiv_iter #(.DIVIDEND_W(DW), .DIVISOR_W(M_W)) u_div2 (
    .clk(clk), .rst_n(rst_n), .start(div_start_q),
    .dividend(diff2), .divisor(ms2_q), .quotient(q2), .done(div2_done)
  );

  assign div_go = div1_done && div2_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms2_q <= '0;
      w2_q  <= '0;
    end else if (accept) begin
      ms2_q <= bus.ms2_in;
      w2_q  <= bus.ws2_in;
    end else if (write_en) begin
      w2_q[idx_q*ELEM_W +: ELEM_W] <= upd2;
    end
  end
`else
  assign div_go = div1_done;

  always_ff @(posedge clk) begin
    if (!rst_n)      w2_q <= '0;
    else if (accept) w2_q <= bus.ws2_in;
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    write_en    = 1'b0;
    publish     = 1'b0;
    last_elem   = (idx_q == IDX_W'(VECTOR_LEN - 1));
    case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = DIV;
      end
      DIV: if (div_go) state_d = WRITE;
      WRITE: begin
        write_en = 1'b1;
        state_d  = last_elem ? DONE : DIV;
      end
      DONE: begin
        // First DONE cycle publishes the results; out_valid follows on that edge.
        if (!out_valid_q) begin
          publish     = 1'b1;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      idx_q       <= '0;
      x_q         <= '0;
      w1_q        <= '0;
      ms1_q       <= '0;
      ths_q       <= '0;
      ws1_out_q   <= '0;
      ws2_out_q   <= '0;
      ths1_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      div_start_q <= (state_d == DIV) && (state_q != DIV);
      if (accept) begin
        idx_q <= '0;
        x_q   <= bus.x_in;
        w1_q  <= bus.ws1_in;
        ms1_q <= bus.ms1_in;
        ths_q <= th_sum[TH_W:1];
      end
      if (write_en) begin
        w1_q[idx_q*ELEM_W +: ELEM_W] <= upd1;
        if (!last_elem) idx_q <= idx_q + IDX_W'(1);
      end
      if (publish) begin
        ws1_out_q  <= w1_q;
        ws2_out_q  <= w2_q;
        ths1_out_q <= ths_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ws1_out   = ws1_out_q;
  assign bus.ws2_out   = ws2_out_q;
  assign bus.ths1_out  = ths1_out_q;
  assign dbg_state     = state_q;
endmodule
